// File: rtl/video_tpg.sv
// video_tpg: AXI4-Stream test pattern source for the HDMI path.
// Emits raster-ordered active pixels (no blanking), 24-bit {B,G,R}, with
// tuser marking pixel (0,0). The output register always holds the pixel at
// (r_x, r_y); the next pixel is computed ahead and loaded on acceptance, so
// back-to-back transfers run at one pixel per clock with no bubbles.
module video_tpg #(
    parameter int H_ACTIVE        = 1920,
    parameter int V_ACTIVE        = 1080,
    parameter int CHECKER_SHIFT   = 5,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       enable_i,
    input  logic [1:0]                 pattern_i,
    input  logic [23:0]                solid_color_i,
    output logic                       out_axis_tvalid_o,
    input  logic                       out_axis_tready_i,
    output logic [23:0]                out_axis_tdata_o,
    output logic                       out_axis_tuser_o,
    output logic                       frame_done_o,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o
);

    localparam int XW    = $clog2(H_ACTIVE);
    localparam int YW    = $clog2(V_ACTIVE);
    localparam int BAR_W = H_ACTIVE / 8;

    localparam logic [XW-1:0] X_LAST     = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(V_ACTIVE - 1);
    localparam logic [XW-1:0] BAR_RELOAD = XW'(BAR_W - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                     r_state;
    logic [XW-1:0]              r_x;
    logic [YW-1:0]              r_y;
    logic [2:0]                 r_bar_idx;
    logic [XW-1:0]              r_bar_rem;
    logic [1:0]                 r_pattern;
    logic [23:0]                r_solid;
    logic                       r_tvalid;
    logic [23:0]                r_tdata;
    logic                       r_tuser;
    logic                       r_frame_done;
    logic [FRAME_CNT_WIDTH-1:0] r_frame_cnt;

    logic          w_accept;
    logic          w_x_last;
    logic          w_y_last;
    logic          w_frame_last;
    logic          w_frame_end;
    logic          w_start;
    logic          w_stop;
    logic          w_advance;
    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;
    logic [2:0]    w_nbar_idx;
    logic [XW-1:0] w_nbar_rem;
    logic [23:0]   w_start_color;
    logic [23:0]   w_next_color;

    // Full-scale bar colours, left to right: W Y C G M R B K.
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'h00FFFF;
            3'd2:    c = 24'hFFFF00;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'h0000FF;
            3'd6:    c = 24'hFF0000;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Colour of one pixel given the frame's pattern selection and position.
    function automatic logic [23:0] pixel_color(
        input logic [1:0]    pat,
        input logic [23:0]   solid,
        input logic [2:0]    bar,
        input logic [XW-1:0] x,
        input logic [YW-1:0] y
    );
        logic [7:0]  grey;
        logic        odd_sq;
        logic [23:0] c;
        grey   = 8'(x);
        // Zero-extend before shifting so small frames still have the bit.
        odd_sq = 1'((32'(x) >> CHECKER_SHIFT) ^ (32'(y) >> CHECKER_SHIFT));
        case (pat)
            2'd0:    c = bar_color(bar);
            2'd1:    c = {grey, grey, grey};
            2'd2:    c = odd_sq ? 24'h000000 : 24'hFFFFFF;
            default: c = solid;
        endcase
        return c;
    endfunction

    // Position, bar tracker and colour of the pixel that follows the current one.
    always_comb begin
        w_accept     = r_tvalid & out_axis_tready_i;
        w_x_last     = (r_x == X_LAST);
        w_y_last     = (r_y == Y_LAST);
        w_frame_last = w_x_last & w_y_last;

        w_nx = w_x_last ? '0 : r_x + XW'(1);
        w_ny = r_y;
        if (w_x_last) begin
            w_ny = w_y_last ? '0 : r_y + YW'(1);
        end

        // Bar index advances when the width down-counter expires; the
        // last bar never advances so it absorbs any remainder pixels.
        w_nbar_idx = r_bar_idx;
        w_nbar_rem = r_bar_rem;
        if (w_x_last) begin
            w_nbar_idx = 3'd0;
            w_nbar_rem = BAR_RELOAD;
        end else if (r_bar_rem == '0) begin
            if (r_bar_idx != 3'd7) begin
                w_nbar_idx = r_bar_idx + 3'd1;
                w_nbar_rem = BAR_RELOAD;
            end
        end else begin
            w_nbar_rem = r_bar_rem - XW'(1);
        end

        w_frame_end = (r_state == ST_RUN) & w_accept & w_frame_last;
        w_start     = ((r_state == ST_IDLE) & enable_i) | (w_frame_end & enable_i);
        w_stop      = w_frame_end & ~enable_i;
        w_advance   = (r_state == ST_RUN) & w_accept & ~w_frame_last;

        // Pixel (0,0) uses the live pattern inputs since they are latched there.
        w_start_color = pixel_color(pattern_i, solid_color_i, 3'd0, '0, '0);
        w_next_color  = pixel_color(r_pattern, r_solid, w_nbar_idx, w_nx, w_ny);
    end

    // Run/idle control, raster counters and registered stream outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= ST_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_bar_idx    <= '0;
            r_bar_rem    <= '0;
            r_pattern    <= '0;
            r_solid      <= '0;
            r_tvalid     <= 1'b0;
            r_tdata      <= '0;
            r_tuser      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_WIDTH'(1);
            end

            if (w_start) begin
                r_state   <= ST_RUN;
                r_x       <= '0;
                r_y       <= '0;
                r_bar_idx <= 3'd0;
                r_bar_rem <= BAR_RELOAD;
                r_pattern <= pattern_i;
                r_solid   <= solid_color_i;
                r_tvalid  <= 1'b1;
                r_tdata   <= w_start_color;
                r_tuser   <= 1'b1;
            end else if (w_stop) begin
                r_state   <= ST_IDLE;
                r_x       <= '0;
                r_y       <= '0;
                r_bar_idx <= 3'd0;
                r_bar_rem <= '0;
                r_tvalid  <= 1'b0;
                r_tdata   <= '0;
                r_tuser   <= 1'b0;
            end else if (w_advance) begin
                r_x       <= w_nx;
                r_y       <= w_ny;
                r_bar_idx <= w_nbar_idx;
                r_bar_rem <= w_nbar_rem;
                r_tdata   <= w_next_color;
                r_tuser   <= 1'b0;
            end
        end
    end

    assign out_axis_tvalid_o = r_tvalid;
    assign out_axis_tdata_o  = r_tdata;
    assign out_axis_tuser_o  = r_tuser;
    assign frame_done_o      = r_frame_done;
    assign frame_cnt_o       = r_frame_cnt;

endmodule

// File: tb/tb_video_tpg.sv
// Directed bench for video_tpg: a 16x4 instance covers all patterns,
// stalls, enable drop, mid-frame pattern changes and async reset; a 19x2
// instance covers the colour-bar remainder handling.
module tb_video_tpg;

    localparam int H  = 16;
    localparam int V  = 4;
    localparam int CS = 1;
    localparam int FW = 16;
    localparam int H2 = 19;
    localparam int V2 = 2;

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                                         24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          en;
    logic          rdy;
    logic [1:0]    pat;
    logic [23:0]   solid;
    logic          tvalid;
    logic          tuser;
    logic          fdone;
    logic [23:0]   tdata;
    logic [FW-1:0] fcnt;

    logic          en2;
    logic          rdy2;
    logic          tvalid2;
    logic          tuser2;
    logic          fdone2;
    logic [23:0]   tdata2;
    logic [FW-1:0] fcnt2;

    int n_vec  = 0;
    int n_miss = 0;

    video_tpg #(.H_ACTIVE(H), .V_ACTIVE(V), .CHECKER_SHIFT(CS), .FRAME_CNT_WIDTH(FW)) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .enable_i          (en),
        .pattern_i         (pat),
        .solid_color_i     (solid),
        .out_axis_tvalid_o (tvalid),
        .out_axis_tready_i (rdy),
        .out_axis_tdata_o  (tdata),
        .out_axis_tuser_o  (tuser),
        .frame_done_o      (fdone),
        .frame_cnt_o       (fcnt)
    );

    video_tpg #(.H_ACTIVE(H2), .V_ACTIVE(V2), .CHECKER_SHIFT(CS), .FRAME_CNT_WIDTH(FW)) dut2 (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .enable_i          (en2),
        .pattern_i         (2'd0),
        .solid_color_i     (24'h000000),
        .out_axis_tvalid_o (tvalid2),
        .out_axis_tready_i (rdy2),
        .out_axis_tdata_o  (tdata2),
        .out_axis_tuser_o  (tuser2),
        .frame_done_o      (fdone2),
        .frame_cnt_o       (fcnt2)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference pixel: bar index by division, capped at the last bar.
    function automatic logic [23:0] exp_pix(input int p, input logic [23:0] s,
                                            input int x, input int y, input int h);
        int         b;
        logic [7:0] g;
        logic [23:0] c;
        case (p)
            0: begin
                b = x / (h / 8);
                if (b > 7) b = 7;
                c = BARS[b];
            end
            1: begin
                g = 8'(x);
                c = {g, g, g};
            end
            2: c = (((x >> CS) ^ (y >> CS)) & 1) != 0 ? 24'h000000 : 24'hFFFFFF;
            default: c = s;
        endcase
        return c;
    endfunction

    // Consume n_beats beats of the 16x4 instance starting at the current
    // negedge. Optionally randomises tready, drops enable or changes the
    // pattern inputs after a given beat, and checks the end-of-frame pulse.
    task automatic collect(input string nm, input int p, input logic [23:0] s,
                           input bit rnd, input int n_beats, input int drop_at,
                           input int sw_at, input logic [1:0] sw_pat, input logic [23:0] sw_solid,
                           input bit end_chk, input int exp_cnt, input bit exp_cont);
        int          beat = 0;
        int          cyc  = 0;
        bit          pend = 1'b0;
        logic [23:0] pd   = '0;
        logic        pu   = 1'b0;
        while (beat < n_beats && cyc < 4000) begin
            cyc++;
            check_vec({nm, "_tvalid"}, 32'(tvalid), 32'd1);
            if (pend) begin
                check_vec({nm, "_hold_data"}, 32'(tdata), 32'(pd));
                check_vec({nm, "_hold_user"}, 32'(tuser), 32'(pu));
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rdy && tvalid) begin
                $display("%s beat %0d: tdata=%06h tuser=%0b", nm, beat, tdata, tuser);
                check_vec({nm, "_data"}, 32'(tdata), 32'(exp_pix(p, s, beat % H, beat / H, H)));
                check_vec({nm, "_user"}, 32'(tuser), 32'(beat == 0));
                beat++;
                pend = 1'b0;
                if (beat == drop_at) en = 1'b0;
                if (beat == sw_at) begin
                    pat   = sw_pat;
                    solid = sw_solid;
                end
            end else begin
                pend = 1'b1;
                pd   = tdata;
                pu   = tuser;
            end
            @(negedge clk);
        end
        if (beat < n_beats) check_vec({nm, "_timeout_beats"}, 32'(beat), 32'(n_beats));
        if (end_chk) begin
            check_vec({nm, "_frame_done"}, 32'(fdone), 32'd1);
            check_vec({nm, "_frame_cnt"}, 32'(fcnt), 32'(exp_cnt));
            check_vec({nm, "_tvalid_after"}, 32'(tvalid), 32'(exp_cont));
            if (exp_cont) check_vec({nm, "_next_tuser"}, 32'(tuser), 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        rdy   = 1'b0;
        pat   = 2'd0;
        solid = 24'h000000;
        en2   = 1'b0;
        rdy2  = 1'b1;

        repeat (3) @(negedge clk);
        check_vec("rst_tvalid", 32'(tvalid), 32'd0);
        check_vec("rst_tdata", 32'(tdata), 32'd0);
        check_vec("rst_tuser", 32'(tuser), 32'd0);
        check_vec("rst_fdone", 32'(fdone), 32'd0);
        check_vec("rst_fcnt", 32'(fcnt), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check_vec("idle_tvalid", 32'(tvalid), 32'd0);

        // Colour bars, continuous run; next frame selected as checkerboard.
        en  = 1'b1;
        pat = 2'd0;
        @(negedge clk);
        check_vec("lat_tvalid", 32'(tvalid), 32'd1);
        collect("bars", 0, 24'h0, 1'b0, H*V, -1, 20, 2'd2, 24'h0, 1'b1, 1, 1'b1);

        // Checkerboard, back-to-back with the previous frame.
        collect("chk", 2, 24'h0, 1'b0, H*V, -1, 5, 2'd1, 24'h0, 1'b1, 2, 1'b1);

        // Grey ramp with random stalls; enable drops at beat 10, pattern
        // switches to solid mid-frame and must not affect this frame.
        collect("ramp", 1, 24'h0, 1'b1, H*V, 10, 12, 2'd3, 24'h123456, 1'b1, 3, 1'b0);
        @(negedge clk);
        check_vec("post_fdone", 32'(fdone), 32'd0);
        check_vec("post_tvalid", 32'(tvalid), 32'd0);
        check_vec("post_fcnt", 32'(fcnt), 32'd3);

        // Solid frame; solid_color_i changes mid-frame, latched value holds.
        en = 1'b1;
        @(negedge clk);
        collect("solid", 3, 24'h123456, 1'b0, 30, -1, 3, 2'd3, 24'hABCDEF, 1'b0, 0, 1'b0);

        // Asynchronous reset between clock edges at beat 30.
        #2 rst_n = 1'b0;
        #1;
        check_vec("arst_tvalid", 32'(tvalid), 32'd0);
        check_vec("arst_tdata", 32'(tdata), 32'd0);
        check_vec("arst_tuser", 32'(tuser), 32'd0);
        check_vec("arst_fcnt", 32'(fcnt), 32'd0);
        check_vec("arst_fdone", 32'(fdone), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        check_vec("rerun_fcnt", 32'(fcnt), 32'd0);
        collect("rerun", 3, 24'hABCDEF, 1'b0, H*V, 1, -1, 2'd0, 24'h0, 1'b1, 1, 1'b0);

        // 19-pixel lines: bars 0-6 two pixels wide, black bar five wide.
        en2 = 1'b1;
        @(negedge clk);
        en2 = 1'b0;
        for (int i = 0; i < H2*V2; i++) begin
            $display("bars19 beat %0d: tdata=%06h tuser=%0b", i, tdata2, tuser2);
            check_vec("bars19_tvalid", 32'(tvalid2), 32'd1);
            check_vec("bars19_data", 32'(tdata2), 32'(exp_pix(0, 24'h0, i % H2, i / H2, H2)));
            check_vec("bars19_user", 32'(tuser2), 32'(i == 0));
            @(negedge clk);
        end
        check_vec("bars19_fdone", 32'(fdone2), 32'd1);
        check_vec("bars19_fcnt", 32'(fcnt2), 32'd1);
        check_vec("bars19_tvalid_after", 32'(tvalid2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
